// File: rtl/divclk_edge_counter_pkg.sv
// Shared constants for the divided-clock edge counter: default counter width,
// FSM state encoding and read-select codes.
package divclk_edge_counter_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] SEL_MAIN = 2'd0;
    localparam logic [1:0] SEL_TWO  = 2'd1;
    localparam logic [1:0] SEL_FOUR = 2'd2;
    localparam logic [1:0] SEL_OVF  = 2'd3;

    localparam int unsigned N_CH = 3;

endpackage

// File: rtl/divclk_edge_counter_if.sv
// Control, read-handshake and status signals of the edge counter.
interface divclk_edge_counter_if #(
    parameter int unsigned CNT_W = divclk_edge_counter_pkg::CNT_W_DEF
);
    logic             main;
    logic             two;
    logic             four;
    logic             start;
    logic             stop;
    logic             clear;
    logic [1:0]       sel;
    logic             rd_req;
    logic             rd_ready;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic [CNT_W-1:0] cnt_main;
    logic [CNT_W-1:0] cnt_two;
    logic [CNT_W-1:0] cnt_four;
    logic [2:0]       ovf;
    logic             busy;

    modport master (
        output main, two, four, start, stop, clear, sel, rd_req, rd_ready,
        input  rd_valid, rd_data, cnt_main, cnt_two, cnt_four, ovf, busy
    );

    modport slave (
        input  main, two, four, start, stop, clear, sel, rd_req, rd_ready,
        output rd_valid, rd_data, cnt_main, cnt_two, cnt_four, ovf, busy
    );
endinterface

// File: rtl/divclk_edge_counter_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic rise_o
);
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= in_i;
    end

    assign rise_o = in_i & ~prev_q;
endmodule

// File: rtl/divclk_edge_counter.sv
// Counts rising edges of three divided clocks while running, with sticky
// wrap flags and a single-entry valid/ready read-capture register.
module divclk_edge_counter
    import divclk_edge_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    divclk_edge_counter_if.slave  bus
);
    logic [N_CH-1:0]  rise;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [2:0]       ovf_q, ovf_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] rd_sel;

    edge_detect u_ed_main (.clk(clk), .reset(reset), .in_i(bus.main), .rise_o(rise[0]));
    edge_detect u_ed_two  (.clk(clk), .reset(reset), .in_i(bus.two),  .rise_o(rise[1]));
    edge_detect u_ed_four (.clk(clk), .reset(reset), .in_i(bus.four), .rise_o(rise[2]));

    // stop wins over a simultaneous start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start && !bus.stop) state_d = ST_RUN;
            ST_RUN:  if (bus.stop)               state_d = ST_HOLD;
            ST_HOLD: if (bus.start && !bus.stop) state_d = ST_RUN;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.clear) begin
            for (int unsigned i = 0; i < N_CH; i++) cnt_d[i] = '0;
            ovf_d = '0;
        end else if (state_q == ST_RUN) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (rise[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (bus.sel)
            SEL_MAIN: rd_sel = cnt_q[0];
            SEL_TWO:  rd_sel = cnt_q[1];
            SEL_FOUR: rd_sel = cnt_q[2];
            SEL_OVF:  rd_sel = CNT_W'(ovf_q);
            default:  rd_sel = '0;
        endcase
    end

    // A request in the release cycle is dropped: capture only when already empty
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (rd_valid_q) begin
            if (bus.rd_ready) rd_valid_d = 1'b0;
        end else if (bus.rd_req) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.cnt_main = cnt_q[0];
    assign bus.cnt_two  = cnt_q[1];
    assign bus.cnt_four = cnt_q[2];
    assign bus.ovf      = ovf_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (state_q == ST_RUN);
endmodule

// File: tb/tb_divclk_edge_counter.sv
// Directed self-checking bench for divclk_edge_counter.
module tb_divclk_edge_counter;
    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    divclk_edge_counter_if #(.CNT_W(W)) bus ();

    divclk_edge_counter #(.CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            case (ch)
                0: bus.main = 1'b1;
                1: bus.two  = 1'b1;
                default: bus.four = 1'b1;
            endcase
            tick();
            bus.main = 1'b0; bus.two = 1'b0; bus.four = 1'b0;
            tick();
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1;
        bus.main = 0; bus.two = 0; bus.four = 0;
        bus.start = 0; bus.stop = 0; bus.clear = 0;
        bus.sel = 2'd0; bus.rd_req = 0; bus.rd_ready = 0;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst_cnt_main", 32'(bus.cnt_main), 0);
        check_eq("rst_ovf",      32'(bus.ovf), 0);
        check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
        check_eq("rst_rd_data",  32'(bus.rd_data), 0);
        check_eq("rst_busy",     32'(bus.busy), 0);

        // stop in IDLE is ignored
        bus.stop = 1; tick(); bus.stop = 0;
        check_eq("idle_stop_busy", 32'(bus.busy), 0);

        bus.start = 1; tick(); bus.start = 0;
        check_eq("start_busy", 32'(bus.busy), 1);

        // main toggles each cycle for 20 cycles -> 10 rises
        for (int k = 0; k < 20; k++) begin
            bus.main = ~bus.main;
            tick();
        end
        check_eq("tog_cnt_main", 32'(bus.cnt_main), 10);
        check_eq("tog_cnt_two",  32'(bus.cnt_two), 0);
        check_eq("tog_cnt_four", 32'(bus.cnt_four), 0);
        check_eq("tog_busy",     32'(bus.busy), 1);

        // read captures pre-update value while a rise is counted
        bus.main = 1; bus.sel = 2'd0; bus.rd_req = 1; tick();
        bus.main = 0; bus.rd_req = 0;
        check_eq("rd0_valid", 32'(bus.rd_valid), 1);
        check_eq("rd0_data",  32'(bus.rd_data), 10);
        check_eq("rd0_cnt",   32'(bus.cnt_main), 11);
        bus.rd_ready = 1; tick(); bus.rd_ready = 0;
        check_eq("rd0_release", 32'(bus.rd_valid), 0);

        // wrap of main
        pulse(0, 244);
        check_eq("pre_wrap_cnt", 32'(bus.cnt_main), 255);
        check_eq("pre_wrap_ovf", 32'(bus.ovf), 0);
        pulse(0, 1);
        check_eq("wrap_cnt", 32'(bus.cnt_main), 0);
        check_eq("wrap_ovf", 32'(bus.ovf), 1);
        bus.sel = 2'd3; bus.rd_req = 1; tick(); bus.rd_req = 0;
        check_eq("rd_ovf_data", 32'(bus.rd_data), 1);
        bus.rd_ready = 1; tick(); bus.rd_ready = 0;
        bus.clear = 1; tick(); bus.clear = 0;
        check_eq("clr_ovf",  32'(bus.ovf), 0);
        check_eq("clr_busy", 32'(bus.busy), 1);

        // edges during HOLD are never counted
        pulse(1, 5);
        check_eq("two_5", 32'(bus.cnt_two), 5);
        bus.stop = 1; tick(); bus.stop = 0;
        check_eq("hold_busy", 32'(bus.busy), 0);
        pulse(1, 4);
        check_eq("hold_two", 32'(bus.cnt_two), 5);
        bus.start = 1; tick(); bus.start = 0;
        check_eq("resume_busy", 32'(bus.busy), 1);
        check_eq("resume_two",  32'(bus.cnt_two), 5);
        pulse(1, 1);
        check_eq("resume_two_6", 32'(bus.cnt_two), 6);

        // captured value stays put while not accepted
        pulse(2, 3);
        check_eq("four_3", 32'(bus.cnt_four), 3);
        bus.sel = 2'd2; bus.rd_req = 1;
        for (int k = 0; k < 5; k++) begin
            bus.four = ~bus.four;
            tick();
            check_eq("hold_rd_valid", 32'(bus.rd_valid), 1);
            check_eq("hold_rd_data",  32'(bus.rd_data), 3);
        end
        bus.four = 0;
        bus.rd_ready = 1; tick();
        check_eq("ready_rd_valid", 32'(bus.rd_valid), 0);
        bus.rd_ready = 0; bus.rd_req = 0; tick();
        check_eq("ready_no_recap", 32'(bus.rd_valid), 0);
        check_eq("four_6", 32'(bus.cnt_four), 6);

        // clear beats a simultaneous increment
        bus.main = 1; bus.clear = 1; tick();
        bus.main = 0; bus.clear = 0; tick();
        check_eq("clr_inc_main", 32'(bus.cnt_main), 0);
        check_eq("clr_inc_four", 32'(bus.cnt_four), 0);

        // start+stop together from IDLE stays IDLE
        reset = 1; tick(); reset = 0;
        bus.start = 1; bus.stop = 1; tick(); bus.start = 0; bus.stop = 0;
        check_eq("ss_busy", 32'(bus.busy), 0);
        pulse(0, 1);
        check_eq("ss_cnt_main", 32'(bus.cnt_main), 0);

        // reset in RUN with a pending read
        bus.start = 1; tick(); bus.start = 0;
        pulse(0, 2);
        bus.sel = 2'd0; bus.rd_req = 1; tick(); bus.rd_req = 0;
        check_eq("pre_rst_valid", 32'(bus.rd_valid), 1);
        check_eq("pre_rst_data",  32'(bus.rd_data), 2);
        reset = 1; bus.start = 1; tick(); reset = 0; bus.start = 0;
        check_eq("rst_run_busy",  32'(bus.busy), 0);
        check_eq("rst_run_cnt",   32'(bus.cnt_main), 0);
        check_eq("rst_run_valid", 32'(bus.rd_valid), 0);
        check_eq("rst_run_data",  32'(bus.rd_data), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
